// File: rtl/nacc_pkg.sv
// Shared types and saturating arithmetic helpers for the NAcc/LIF engine.
// Arithmetic is carried in a 64-bit signed container and clamped to a given width.
package nacc_pkg;

  localparam int unsigned WideW = 64;
  typedef logic signed [WideW-1:0] wide_t;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StInteg,
    StDone
  } nacc_state_e;

  function automatic wide_t cur_max(int unsigned w);
    return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
  endfunction

  function automatic wide_t cur_min(int unsigned w);
    return -(wide_t'(1) <<< (w - 1));
  endfunction

  function automatic wide_t sat_wide(wide_t v, int unsigned w);
    if (v > cur_max(w)) return cur_max(w);
    if (v < cur_min(w)) return cur_min(w);
    return v;
  endfunction

  function automatic wide_t sat_add(wide_t a, wide_t b, int unsigned w);
    return sat_wide(a + b, w);
  endfunction

endpackage

// File: rtl/nacc_row_sum.sv
// Combinational masked signed sum of one weight row, saturated to CUR_WIDTH.
module nacc_row_sum
  import nacc_pkg::*;
#(
  parameter int unsigned SYN       = 32,
  parameter int unsigned W_WIDTH   = 8,
  parameter int unsigned CUR_WIDTH = 32
) (
  input  logic [SYN-1:0]                spike_i,
  input  logic [SYN*W_WIDTH-1:0]        w_data_i,
  output logic signed [CUR_WIDTH-1:0]   sum_o
);

  wide_t                      acc;
  logic signed [W_WIDTH-1:0]  w;

  // Full-precision sum first; the clamp happens once at the end.
  always_comb begin
    acc = '0;
    w   = '0;
    for (int j = 0; j < SYN; j++) begin
      w = w_data_i[j*W_WIDTH +: W_WIDTH];
      if (spike_i[j]) begin
        acc = acc + wide_t'(w);
      end
    end
    sum_o = CUR_WIDTH'(sat_wide(acc, CUR_WIDTH));
  end

endmodule

// File: rtl/nacc_lif_engine.sv
// Neuron accumulate + leaky integrate-and-fire engine: one weight row per neuron is
// accumulated, then all neurons integrate, fire and enter refractory in a single cycle.
module nacc_lif_engine
  import nacc_pkg::*;
#(
  parameter int unsigned NEURONS   = 16,
  parameter int unsigned SYN       = 32,
  parameter int unsigned W_WIDTH   = 8,
  parameter int unsigned CUR_WIDTH = 32,
  parameter int unsigned REF_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           clear,
  input  logic [SYN-1:0]                 spike_in,
  input  logic [CUR_WIDTH-1:0]           vth,
  input  logic [4:0]                     leak_shift,
  input  logic [REF_WIDTH-1:0]           ref_period,
  input  logic                           w_valid,
  output logic                           w_ready,
  input  logic [SYN*W_WIDTH-1:0]         w_data,
  output logic                           busy,
  output logic                           done,
  output logic [NEURONS-1:0]             spike_out,
  output logic [NEURONS*CUR_WIDTH-1:0]   vmem_out
);

  localparam int unsigned IdxW = (NEURONS > 1) ? $clog2(NEURONS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NEURONS - 1);

  nacc_state_e state_q, state_d;

  logic [SYN-1:0]                spike_lat_q;
  logic signed [CUR_WIDTH-1:0]   vth_q;
  logic [4:0]                    leak_q;
  logic [REF_WIDTH-1:0]          ref_q;
  logic [IdxW-1:0]               idx_q;

  logic signed [CUR_WIDTH-1:0]   cur_q    [NEURONS];
  logic signed [CUR_WIDTH-1:0]   vmem_q   [NEURONS];
  logic [REF_WIDTH-1:0]          refcnt_q [NEURONS];
  logic [NEURONS-1:0]            spk_q;

  logic signed [CUR_WIDTH-1:0]   vmem_nxt [NEURONS];
  logic [REF_WIDTH-1:0]          ref_nxt  [NEURONS];
  logic [NEURONS-1:0]            spk_nxt;

  logic signed [CUR_WIDTH-1:0]   row_sum;
  logic                          beat;

  nacc_row_sum #(
    .SYN       (SYN),
    .W_WIDTH   (W_WIDTH),
    .CUR_WIDTH (CUR_WIDTH)
  ) u_row_sum (
    .spike_i  (spike_lat_q),
    .w_data_i (w_data),
    .sum_o    (row_sum)
  );

  assign w_ready = (state_q == StAccum);
  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);
  assign beat    = w_valid && w_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StAccum;
      StAccum: if (beat && idx_q == LastIdx) state_d = StInteg;
      StInteg: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  for (genvar n = 0; n < NEURONS; n++) begin : g_lif
    wide_t                        leak_w;
    wide_t                        v_new;
    logic signed [CUR_WIDTH-1:0]  vnext;
    logic [REF_WIDTH-1:0]         rnext;
    logic                         snext;

    always_comb begin
      leak_w = (leak_q != '0) ? wide_t'(vmem_q[n] >>> leak_q) : '0;
      v_new  = sat_add(wide_t'(vmem_q[n]) - leak_w, wide_t'(cur_q[n]), CUR_WIDTH);
      vnext  = '0;
      rnext  = '0;
      snext  = 1'b0;
      if (refcnt_q[n] != '0) begin
        rnext = refcnt_q[n] - REF_WIDTH'(1);
      end else if (v_new >= wide_t'(vth_q)) begin
        snext = 1'b1;
        rnext = ref_q;
      end else begin
        vnext = CUR_WIDTH'(v_new);
      end
    end

    assign vmem_nxt[n] = vnext;
    assign ref_nxt[n]  = rnext;
    assign spk_nxt[n]  = snext;
    assign vmem_out[n*CUR_WIDTH +: CUR_WIDTH] = vmem_q[n];
  end

  assign spike_out = spk_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      spike_lat_q <= '0;
      vth_q       <= '0;
      leak_q      <= '0;
      ref_q       <= '0;
      idx_q       <= '0;
      spk_q       <= '0;
      for (int n = 0; n < NEURONS; n++) begin
        cur_q[n]    <= '0;
        vmem_q[n]   <= '0;
        refcnt_q[n] <= '0;
      end
    end else begin
      state_q <= state_d;
      unique case (state_q)
        StIdle: begin
          // Clear and start may coincide: zeroing happens, then the step runs on clean state.
          if (clear) begin
            spk_q <= '0;
            for (int n = 0; n < NEURONS; n++) begin
              vmem_q[n]   <= '0;
              refcnt_q[n] <= '0;
            end
          end
          if (start) begin
            spike_lat_q <= spike_in;
            vth_q       <= vth;
            leak_q      <= leak_shift;
            ref_q       <= ref_period;
            idx_q       <= '0;
            for (int n = 0; n < NEURONS; n++) begin
              cur_q[n] <= '0;
            end
          end
        end
        StAccum: begin
          if (beat) begin
            cur_q[idx_q] <= row_sum;
            idx_q        <= idx_q + IdxW'(1);
          end
        end
        StInteg: begin
          spk_q <= spk_nxt;
          for (int n = 0; n < NEURONS; n++) begin
            vmem_q[n]   <= vmem_nxt[n];
            refcnt_q[n] <= ref_nxt[n];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nacc_lif_engine.sv
// Directed bench for nacc_lif_engine at NEURONS=4, SYN=8, W_WIDTH=8, CUR_WIDTH=16.
module tb_nacc_lif_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, clear, w_valid;
  logic [7:0]  spike_in;
  logic [15:0] vth;
  logic [4:0]  leak_shift;
  logic [3:0]  ref_period;
  logic [63:0] w_data;
  logic        w_ready, busy, done;
  logic [3:0]  spike_out;
  logic [63:0] vmem_out;

  int n_checks = 0;
  int n_errors = 0;

  nacc_lif_engine #(
    .NEURONS   (4),
    .SYN       (8),
    .W_WIDTH   (8),
    .CUR_WIDTH (16),
    .REF_WIDTH (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .clear      (clear),
    .spike_in   (spike_in),
    .vth        (vth),
    .leak_shift (leak_shift),
    .ref_period (ref_period),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .w_data     (w_data),
    .busy       (busy),
    .done       (done),
    .spike_out  (spike_out),
    .vmem_out   (vmem_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rep4(input logic [15:0] v);
    return {v, v, v, v};
  endfunction

  // One full timestep; returns at a negedge with the engine back in IDLE.
  task automatic do_step(input logic [7:0] sp, input logic [7:0] w, input logic [15:0] th,
                         input logic [4:0] ls, input logic [3:0] rp, input bit gaps,
                         input bit hold_start, input bit with_clear);
    int beats;
    int cyc;
    @(negedge clk);
    start      = 1'b1;
    clear      = with_clear;
    spike_in   = sp;
    vth        = th;
    leak_shift = ls;
    ref_period = rp;
    w_data     = {8{w}};
    @(negedge clk);
    start = hold_start;
    clear = 1'b0;
    if (hold_start) spike_in = 8'h00;
    beats = 0;
    cyc   = 0;
    while (beats < 4 && cyc < 200) begin
      w_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (w_valid && w_ready) beats++;
      @(negedge clk);
      cyc++;
    end
    w_valid = 1'b0;
    start   = 1'b0;
    check("beats_accepted", 64'(beats), 64'd4);
    check("done_low_in_integ", {63'd0, done}, 64'd0);
    check("w_ready_low_in_integ", {63'd0, w_ready}, 64'd0);
    @(negedge clk);
    check("done_pulse", {63'd0, done}, 64'd1);
    @(negedge clk);
    check("done_one_cycle", {63'd0, done}, 64'd0);
    check("idle_after_done", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; clear = 1'b0; w_valid = 1'b0;
    spike_in = '0; vth = '0; leak_shift = '0; ref_period = '0; w_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_w_ready", {63'd0, w_ready}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_spike", {60'd0, spike_out}, 64'd0);
    check("rst_vmem", vmem_out, 64'd0);
    w_valid = 1'b1;
    w_data  = {8{8'h11}};
    repeat (3) begin
      @(negedge clk);
      check("idle_w_ready", {63'd0, w_ready}, 64'd0);
    end
    w_valid = 1'b0;
    check("idle_wvalid_vmem", vmem_out, 64'd0);

    // Basic accumulate then fire and refractory with ref_period=2.
    do_step(8'h0F, 8'h01, 16'd10, 5'd0, 4'd2, 1'b0, 1'b0, 1'b0);
    check("basic_vmem", vmem_out, rep4(16'd4));
    check("basic_spike", {60'd0, spike_out}, 64'd0);
    do_step(8'h0F, 8'h01, 16'd10, 5'd0, 4'd2, 1'b1, 1'b0, 1'b0);
    check("gaps_vmem8", vmem_out, rep4(16'd8));
    do_step(8'h0F, 8'h01, 16'd10, 5'd0, 4'd2, 1'b1, 1'b0, 1'b0);
    check("fire_spike", {60'd0, spike_out}, 64'hF);
    check("fire_vmem", vmem_out, 64'd0);
    do_step(8'h0F, 8'h01, 16'd10, 5'd0, 4'd2, 1'b0, 1'b0, 1'b0);
    check("refr1_vmem", vmem_out, 64'd0);
    check("refr1_spike", {60'd0, spike_out}, 64'd0);
    do_step(8'h0F, 8'h01, 16'd10, 5'd0, 4'd2, 1'b0, 1'b0, 1'b0);
    check("refr2_vmem", vmem_out, 64'd0);
    do_step(8'h0F, 8'h01, 16'd10, 5'd0, 4'd2, 1'b0, 1'b0, 1'b0);
    check("post_refr_vmem", vmem_out, rep4(16'd4));

    // Clear alone in IDLE.
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    check("clear_vmem", vmem_out, 64'd0);

    // Negative weights.
    do_step(8'hFF, 8'hFF, 16'd10, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    check("neg_vmem", vmem_out, rep4(16'hFFF8));

    // Saturation: start+clear together, 1016 per step, clamp at 32767 hits vth.
    do_step(8'hFF, 8'h7F, 16'h7FFF, 5'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    check("clr_start_vmem", vmem_out, rep4(16'd1016));
    for (int i = 2; i <= 32; i++) begin
      do_step(8'hFF, 8'h7F, 16'h7FFF, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    end
    check("sat_pre_vmem", vmem_out, rep4(16'd32512));
    check("sat_pre_spike", {60'd0, spike_out}, 64'd0);
    do_step(8'hFF, 8'h7F, 16'h7FFF, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    check("sat_fire_spike", {60'd0, spike_out}, 64'hF);
    check("sat_fire_vmem", vmem_out, 64'd0);
    do_step(8'hFF, 8'h7F, 16'h7FFF, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    check("no_refr_vmem", vmem_out, rep4(16'd1016));

    // Leak: 8 -> 4 -> 2 -> 1 -> 1.
    do_step(8'h0F, 8'h02, 16'd100, 5'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    check("leak_pre", vmem_out, rep4(16'd8));
    do_step(8'h00, 8'h02, 16'd100, 5'd1, 4'd0, 1'b0, 1'b0, 1'b0);
    check("leak_4", vmem_out, rep4(16'd4));
    do_step(8'h00, 8'h02, 16'd100, 5'd1, 4'd0, 1'b1, 1'b0, 1'b0);
    check("leak_2", vmem_out, rep4(16'd2));
    do_step(8'h00, 8'h02, 16'd100, 5'd1, 4'd0, 1'b0, 1'b0, 1'b0);
    check("leak_1", vmem_out, rep4(16'd1));
    do_step(8'h00, 8'h02, 16'd100, 5'd1, 4'd0, 1'b0, 1'b0, 1'b0);
    check("leak_floor", vmem_out, rep4(16'd1));

    // start held high (with altered spike_in) during ACCUM must be ignored.
    do_step(8'h0F, 8'h01, 16'd100, 5'd0, 4'd0, 1'b1, 1'b1, 1'b1);
    check("start_in_accum_vmem", vmem_out, rep4(16'd4));

    // Reset after two beats: everything cleared, no done.
    @(negedge clk);
    start = 1'b1; spike_in = 8'h0F; w_data = {8{8'h01}}; vth = 16'd100;
    @(negedge clk);
    start = 1'b0; w_valid = 1'b1;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    w_valid = 1'b0;
    #1;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_vmem", vmem_out, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("midrst_no_done", {63'd0, done}, 64'd0);
    end
    check("midrst_w_ready", {63'd0, w_ready}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
